// File: rtl/riscv_id_stage.sv
// Decode/issue stage: decodes fetched instructions into ALU operands, tracks
// in-flight destinations with a busy-bit scoreboard, and holds one result for EX.
module riscv_id_stage #(
    parameter int WORD_LENGTH = 32,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [31:0]            if_inst,
    input  logic [WORD_LENGTH-1:0] if_pc,
    output logic [REG_ADDR_W-1:0]  rs1_addr,
    output logic [REG_ADDR_W-1:0]  rs2_addr,
    input  logic [WORD_LENGTH-1:0] rs1_data,
    input  logic [WORD_LENGTH-1:0] rs2_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [3:0]             ex_exec_fun,
    output logic [WORD_LENGTH-1:0] ex_data1,
    output logic [WORD_LENGTH-1:0] ex_data2,
    output logic [REG_ADDR_W-1:0]  ex_rd,
    output logic                   ex_wb_en,
    output logic [1:0]             ex_br_type,
    output logic [WORD_LENGTH-1:0] ex_br_target,
    output logic                   ex_illegal,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic                   flush
);

    localparam int NREG = 1 << REG_ADDR_W;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [REG_ADDR_W-1:0] inst_rd;

    assign opcode   = if_inst[6:0];
    assign funct3   = if_inst[14:12];
    assign funct7   = if_inst[31:25];
    assign inst_rd  = if_inst[7 +: REG_ADDR_W];
    assign rs1_addr = if_inst[15 +: REG_ADDR_W];
    assign rs2_addr = if_inst[20 +: REG_ADDR_W];

    logic [WORD_LENGTH-1:0] imm_i, imm_u, imm_b;
    assign imm_i = WORD_LENGTH'($signed(if_inst[31:20]));
    assign imm_u = WORD_LENGTH'($signed({if_inst[31:12], 12'b0}));
    assign imm_b = WORD_LENGTH'($signed({if_inst[31], if_inst[7], if_inst[30:25],
                                         if_inst[11:8], 1'b0}));

    logic [3:0]             dec_fun;
    logic [WORD_LENGTH-1:0] dec_d1, dec_d2, dec_tgt;
    logic [REG_ADDR_W-1:0]  dec_rd;
    logic                   dec_wb, dec_ill, use1, use2;
    logic [1:0]             dec_br;

    always_comb begin
        dec_fun = ALU_ADD;
        dec_d1  = '0;
        dec_d2  = '0;
        dec_tgt = '0;
        dec_rd  = '0;
        dec_wb  = 1'b0;
        dec_br  = 2'b00;
        dec_ill = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        case (opcode)
            OP_R: begin
                use1   = 1'b1;
                use2   = 1'b1;
                dec_d1 = rs1_data;
                dec_d2 = rs2_data;
                dec_rd = inst_rd;
                dec_wb = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_fun = ALU_ADD;
                    {7'b0100000, 3'b000}: dec_fun = ALU_SUB;
                    {7'b0000000, 3'b010}: dec_fun = ALU_SLT;
                    {7'b0000000, 3'b110}: dec_fun = ALU_OR;
                    {7'b0000000, 3'b111}: dec_fun = ALU_AND;
                    default:              dec_ill = 1'b1;
                endcase
            end
            OP_I: begin
                use1   = 1'b1;
                dec_d1 = rs1_data;
                dec_d2 = imm_i;
                dec_rd = inst_rd;
                dec_wb = 1'b1;
                case (funct3)
                    3'b000:  dec_fun = ALU_ADD;
                    3'b010:  dec_fun = ALU_SLT;
                    3'b110:  dec_fun = ALU_OR;
                    3'b111:  dec_fun = ALU_AND;
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec_d2 = imm_u;
                dec_rd = inst_rd;
                dec_wb = 1'b1;
            end
            OP_BR: begin
                use1    = 1'b1;
                use2    = 1'b1;
                dec_fun = ALU_SUB;
                dec_d1  = rs1_data;
                dec_d2  = rs2_data;
                dec_tgt = if_pc + imm_b;
                case (funct3)
                    3'b000:  dec_br  = 2'b01;
                    3'b001:  dec_br  = 2'b10;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings collapse to an inert NOP-like bundle with no sources.
        if (dec_ill) begin
            dec_fun = ALU_ADD;
            dec_d1  = '0;
            dec_d2  = '0;
            dec_tgt = '0;
            dec_rd  = '0;
            dec_wb  = 1'b0;
            dec_br  = 2'b00;
            use1    = 1'b0;
            use2    = 1'b0;
        end
        if (dec_rd == '0) dec_wb = 1'b0;
    end

    logic [NREG-1:0] busy, busy_next;
    logic            hazard, accept;

    assign hazard   = (use1 && busy[rs1_addr]) || (use2 && busy[rs2_addr]);
    assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
    assign accept   = if_valid && if_ready;

    // Clears are applied before the set so an issue to the same register wins.
    always_comb begin
        busy_next = busy;
        if (wb_valid) busy_next[wb_rd] = 1'b0;
        if (flush && ex_valid && ex_wb_en) busy_next[ex_rd] = 1'b0;
        if (accept && dec_wb) busy_next[dec_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy         <= '0;
            ex_valid     <= 1'b0;
            ex_exec_fun  <= ALU_ADD;
            ex_data1     <= '0;
            ex_data2     <= '0;
            ex_rd        <= '0;
            ex_wb_en     <= 1'b0;
            ex_br_type   <= 2'b00;
            ex_br_target <= '0;
            ex_illegal   <= 1'b0;
        end else begin
            busy <= busy_next;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (accept) begin
                ex_valid     <= 1'b1;
                ex_exec_fun  <= dec_fun;
                ex_data1     <= dec_d1;
                ex_data2     <= dec_d2;
                ex_rd        <= dec_rd;
                ex_wb_en     <= dec_wb;
                ex_br_type   <= dec_br;
                ex_br_target <= dec_tgt;
                ex_illegal   <= dec_ill;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_id_stage.sv
// Scenario bench for riscv_id_stage: expected EX bundles are queued as each
// instruction is driven and compared once the stage presents it.
module tb_riscv_id_stage;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    typedef struct packed {
        logic [3:0]  fun;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        wb;
        logic [1:0]  br;
        logic [31:0] tgt;
        logic        ill;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_exec_fun;
    logic [31:0] ex_data1, ex_data2;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic [1:0]  ex_br_type;
    logic [31:0] ex_br_target;
    logic        ex_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    int unsigned checks = 0;
    int unsigned passed = 0;
    ex_t sb[$];
    ex_t exp_v, got_v;

    riscv_id_stage #(.WORD_LENGTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_exec_fun(ex_exec_fun),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
        .ex_br_type(ex_br_type), .ex_br_target(ex_br_target), .ex_illegal(ex_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    function automatic ex_t mk(input logic [3:0] fun, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [4:0] rd, input logic wb, input logic [1:0] br,
                               input logic [31:0] tgt, input logic ill);
        ex_t e;
        e.fun = fun; e.d1 = d1; e.d2 = d2; e.rd = rd; e.wb = wb; e.br = br; e.tgt = tgt; e.ill = ill;
        return e;
    endfunction

    function automatic ex_t outputs();
        ex_t e;
        e.fun = ex_exec_fun; e.d1 = ex_data1; e.d2 = ex_data2; e.rd = ex_rd; e.wb = ex_wb_en;
        e.br = ex_br_type; e.tgt = ex_br_target; e.ill = ex_illegal;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2, input logic er,
                         input logic wv, input logic [4:0] wr, input logic fl);
        @(negedge clk);
        if_valid = v; if_inst = inst; if_pc = pc; rs1_data = d1; rs2_data = d2;
        ex_ready = er; wb_valid = wv; wb_rd = wr; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 32'h00500093, 0, 0, 0, 1, 1, 5'd1, 1);
        tick();
        drive(1, 32'h00500093, 0, 0, 0, 1, 1, 5'd1, 1);
        tick();
        checks++;
        if (ex_valid !== 1'b0) $display("FAIL reset_valid: ex_valid=%b want 0", ex_valid);
        else passed++;
        got_v = outputs();
        exp_v = mk(ALU_ADD, 0, 0, 0, 0, 2'b00, 0, 0);
        checks++;
        if (got_v !== exp_v) $display("FAIL reset_fields: got %h want %h", got_v, exp_v);
        else passed++;
        rst_n = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL reset_ready: if_ready=%b want 1", if_ready);
        else passed++;
    endtask

    task automatic test_addi();
        drive(1, 32'h00500093, 32'h0, 32'h0, 32'h0, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL addi_ready: if_ready=%b want 1", if_ready);
        else passed++;
        sb.push_back(mk(ALU_ADD, 32'd0, 32'd5, 5'd1, 1, 2'b00, 0, 0));
        tick();
        checks++;
        if (ex_valid !== 1'b1) $display("FAIL addi_valid: ex_valid=%b want 1", ex_valid);
        else passed++;
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v) $display("FAIL addi_fields: got %h want %h", got_v, exp_v);
        else passed++;
    endtask

    task automatic test_raw_stall();
        drive(1, 32'h002081B3, 0, 32'h11, 32'h22, 1, 0, 5'd0, 0);
        checks++;
        if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2})
            $display("FAIL raw_addrs: rs1=%0d rs2=%0d want 1 2", rs1_addr, rs2_addr);
        else passed++;
        checks++;
        if (if_ready !== 1'b0) $display("FAIL raw_stall: if_ready=%b want 0", if_ready);
        else passed++;
        tick();
        checks++;
        if (ex_valid !== 1'b0) $display("FAIL raw_drain: ex_valid=%b want 0", ex_valid);
        else passed++;
        drive(1, 32'h002081B3, 0, 32'h11, 32'h22, 1, 1, 5'd1, 0);
        checks++;
        if (if_ready !== 1'b0) $display("FAIL raw_no_bypass: if_ready=%b want 0", if_ready);
        else passed++;
        tick();
        drive(1, 32'h002081B3, 0, 32'h11, 32'h22, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL raw_resume: if_ready=%b want 1", if_ready);
        else passed++;
        sb.push_back(mk(ALU_ADD, 32'h11, 32'h22, 5'd3, 1, 2'b00, 0, 0));
        tick();
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v || ex_valid !== 1'b1)
            $display("FAIL raw_add: got %h v=%b want %h v=1", got_v, ex_valid, exp_v);
        else passed++;
        drive(0, 32'h0, 0, 0, 0, 1, 1, 5'd3, 0);
        tick();
    endtask

    task automatic test_branch();
        drive(1, 32'hFE208CE3, 32'h100, 32'd7, 32'd7, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL beq_ready: if_ready=%b want 1", if_ready);
        else passed++;
        sb.push_back(mk(ALU_SUB, 32'd7, 32'd7, 5'd0, 0, 2'b01, 32'hF8, 0));
        tick();
        got_v = outputs();
        checks++;
        if (got_v !== sb[0] || ex_valid !== 1'b1)
            $display("FAIL beq_fields: got %h v=%b want %h v=1", got_v, ex_valid, sb[0]);
        else passed++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hABCDE2B7, 32'h104, 0, 0, 0, 0, 5'd0, 0);
            checks++;
            if (if_ready !== 1'b0) $display("FAIL bp_ready_%0d: if_ready=%b want 0", i, if_ready);
            else passed++;
            tick();
            got_v = outputs();
            checks++;
            if (got_v !== sb[0] || ex_valid !== 1'b1)
                $display("FAIL bp_hold_%0d: got %h v=%b want %h v=1", i, got_v, ex_valid, sb[0]);
            else passed++;
        end
        drive(1, 32'hABCDE2B7, 32'h104, 0, 0, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL bp_release: if_ready=%b want 1", if_ready);
        else passed++;
        void'(sb.pop_front());
        sb.push_back(mk(ALU_ADD, 32'd0, 32'hABCDE000, 5'd5, 1, 2'b00, 0, 0));
        tick();
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v || ex_valid !== 1'b1)
            $display("FAIL lui_fields: got %h v=%b want %h v=1", got_v, ex_valid, exp_v);
        else passed++;
        drive(0, 32'h0, 0, 0, 0, 1, 1, 5'd5, 0);
        tick();
    endtask

    task automatic test_flush();
        drive(1, 32'h00300213, 0, 0, 0, 1, 0, 5'd0, 0);
        sb.push_back(mk(ALU_ADD, 32'd0, 32'd3, 5'd4, 1, 2'b00, 0, 0));
        tick();
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v) $display("FAIL flush_addi4: got %h want %h", got_v, exp_v);
        else passed++;
        drive(1, 32'h00900393, 0, 0, 0, 1, 0, 5'd0, 1);
        checks++;
        if (if_ready !== 1'b0) $display("FAIL flush_ready: if_ready=%b want 0", if_ready);
        else passed++;
        tick();
        checks++;
        if (ex_valid !== 1'b0) $display("FAIL flush_squash: ex_valid=%b want 0", ex_valid);
        else passed++;
        drive(1, 32'h00120313, 0, 32'h40, 0, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL flush_busy_clear: if_ready=%b want 1", if_ready);
        else passed++;
        sb.push_back(mk(ALU_ADD, 32'h40, 32'd1, 5'd6, 1, 2'b00, 0, 0));
        tick();
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v) $display("FAIL flush_next: got %h want %h", got_v, exp_v);
        else passed++;
    endtask

    task automatic test_set_wins();
        drive(1, 32'h00200313, 0, 0, 0, 1, 1, 5'd6, 0);
        sb.push_back(mk(ALU_ADD, 32'd0, 32'd2, 5'd6, 1, 2'b00, 0, 0));
        tick();
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v) $display("FAIL setwin_issue: got %h want %h", got_v, exp_v);
        else passed++;
        drive(1, 32'h00030433, 0, 0, 0, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b0) $display("FAIL setwin_busy: if_ready=%b want 0", if_ready);
        else passed++;
        tick();
        drive(1, 32'h00030433, 0, 0, 0, 1, 1, 5'd6, 0);
        tick();
        drive(1, 32'h00030433, 0, 32'h9, 32'h0, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL setwin_resume: if_ready=%b want 1", if_ready);
        else passed++;
        sb.push_back(mk(ALU_ADD, 32'h9, 32'h0, 5'd8, 1, 2'b00, 0, 0));
        tick();
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v) $display("FAIL setwin_add: got %h want %h", got_v, exp_v);
        else passed++;
        drive(0, 32'h0, 0, 0, 0, 1, 1, 5'd8, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, 32'h0000007F, 32'h200, 32'h55, 32'h66, 1, 0, 5'd0, 0);
        sb.push_back(mk(ALU_ADD, 0, 0, 5'd0, 0, 2'b00, 0, 1));
        tick();
        drive(1, 32'h00100013, 32'h204, 32'h0, 32'h0, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL b2b_ready: if_ready=%b want 1", if_ready);
        else passed++;
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v || ex_valid !== 1'b1)
            $display("FAIL illegal_fields: got %h v=%b want %h v=1", got_v, ex_valid, exp_v);
        else passed++;
        sb.push_back(mk(ALU_ADD, 32'd0, 32'd1, 5'd0, 0, 2'b00, 0, 0));
        tick();
        exp_v = sb.pop_front();
        got_v = outputs();
        checks++;
        if (got_v !== exp_v || ex_valid !== 1'b1)
            $display("FAIL addi_x0: got %h v=%b want %h v=1", got_v, ex_valid, exp_v);
        else passed++;
        drive(1, 32'h00030433, 0, 32'h3, 32'h0, 1, 0, 5'd0, 0);
        checks++;
        if (if_ready !== 1'b1) $display("FAIL x0_no_busy: if_ready=%b want 1", if_ready);
        else passed++;
        tick();
        drive(0, 32'h0, 0, 0, 0, 1, 1, 5'd8, 0);
        tick();
    endtask

    initial begin
        if_valid = 0; if_inst = 0; if_pc = 0; rs1_data = 0; rs2_data = 0;
        ex_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0; rst_n = 0;
        test_reset();
        test_addi();
        test_raw_stall();
        test_branch();
        test_backpressure();
        test_flush();
        test_set_wins();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/riscv_id_stage.md
# riscv_id_stage

Decode/issue stage feeding `riscv_alu`. It accepts fetched instructions over a valid/ready handshake and reads the register file. It decodes each instruction into the ALU's `exec_fun`/`data1`/`data2` operands plus writeback and branch control, and holds the result in one output register toward EX. A busy-bit scoreboard stalls issue on read-after-write hazards, and a flush input squashes the held instruction on a taken branch.

## Interface
- `WORD_LENGTH`, 32, datapath width
- `REG_ADDR_W`, 5, register index width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `if_valid`  in  1  fetch has an instruction
- `if_ready`  out  1  stage accepts instruction this cycle
- `if_inst`  in  32  instruction word
- `if_pc`  in  WORD_LENGTH  instruction address
- `rs1_addr`, `rs2_addr`  out  REG_ADDR_W  register-file read addresses; combinational from `if_inst[19:15]` and `if_inst[24:20]`
- `rs1_data`, `rs2_data`  in  WORD_LENGTH  register-file read data, same cycle
- `ex_valid`  out  1  output register holds an instruction
- `ex_ready`  in  1  EX consumes output this cycle
- `ex_exec_fun`  out  EXEC_FUN  ALU operation
- `ex_data1`, `ex_data2`  out  WORD_LENGTH  ALU operands
- `ex_rd`  out  REG_ADDR_W  destination register
- `ex_wb_en`  out  1  result is written back
- `ex_br_type`  out  2  00 none, 01 BEQ, 10 BNE
- `ex_br_target`  out  WORD_LENGTH  pc + B-immediate
- `ex_illegal`  out  1  undecodable instruction
- `wb_valid`  in  1  writeback retiring a result this cycle
- `wb_rd`  in  REG_ADDR_W  register being written back
- `flush`  in  1  taken branch in EX; squash the younger instruction held here

## Operation
- Decode rules:
  - R-type (opcode 0110011), funct7/funct3 pairs:
    - 0000000/000: ADD → ALU_ADD
    - 0100000/000: SUB → ALU_SUB
    - 0000000/010: SLT → ALU_SLT
    - 0000000/110: OR → ALU_OR
    - 0000000/111: AND → ALU_AND
    - R-type operands: data1=rs1_data, data2=rs2_data, wb_en=1.
  - I-type (0010011):
    - funct3 000/010/110/111 maps to ADDI/SLTI/ORI/ANDI with the same functions.
    - Operands: data2 = sign-extended imm[31:20], uses rs1 only, wb_en=1.
  - LUI (0110111): ALU_ADD, data1=0, data2={inst[31:12],12'b0}, no source registers, wb_en=1.
  - BEQ/BNE (1100011, funct3 000/001):
    - exec_fun=ALU_SUB, data1=rs1_data, data2=rs2_data, wb_en=0.
    - ex_br_type 01/10; target = if_pc + sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}, mod 2^WORD_LENGTH.
  - Anything else: ex_illegal=1, wb_en=0, exec_fun=ALU_ADD, data1=data2=0, br_type=00.
- Writes with rd=0: wb_en forced 0.
- Scoreboard: busy[31:1], busy[0] hardwired 0.
  - hazard = (uses rs1 && busy[rs1]) || (uses rs2 && busy[rs2]).
  - if_ready = (!ex_valid || ex_ready) && !hazard && !flush. Computed from registered state and flush.
  - Accept = if_valid && if_ready: output register loads the decoded fields and ex_valid←1. If wb_en, busy[rd]←1.
  - ex_valid && ex_ready without accept: ex_valid←0, fields hold.
  - wb_valid: busy[wb_rd]←0. A set and a clear of the same register in one cycle: set wins.
  - Writeback does not bypass: a hazard clears the cycle after the busy bit falls.
- Flush:
  - ex_valid←0, regardless of ex_ready.
  - If the held instruction has ex_valid && ex_wb_en, busy[ex_rd]←0.
  - No accept in a flush cycle.
  - Busy bits of older in-flight instructions are untouched.
- Reset (rst_n=0 at clock edge):
  - ex_valid=0, all busy=0.
  - ex_exec_fun=ALU_ADD; ex_data1, ex_data2, ex_rd, ex_wb_en, ex_br_type, ex_br_target, ex_illegal all 0.
  - Reset overrides flush, accept and wb. if_ready reads 1 the cycle after reset.

## Timing
- Latency: instruction accepted at edge N appears with ex_valid=1 after edge N; EX may consume it in cycle N+1.
- Throughput: one instruction per cycle when ex_ready=1 and there are no hazards.
- Output fields are stable while ex_valid=1 && ex_ready=0.
- rs*_addr and if_ready are combinational; register-file read is asynchronous in the same cycle.
- Dependent back-to-back instructions stall until wb_valid for the producer; issue resumes the following cycle.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) at pc 0 → next cycle ex_valid=1, ALU_ADD, data1=0, data2=5, rd=1, wb_en=1; busy[1]=1.
- ADD x3,x1,x2 while busy[1]=1 → if_ready=0. wb_valid with wb_rd=1 → accepted one cycle later.
- BEQ x1,x2,-8 at pc 0x100 with rs1=rs2=7 → ALU_SUB, br_type=01, br_target=0xF8, wb_en=0, no busy change.
- Hold ex_ready=0 for 3 cycles with an instruction held → outputs stable, if_ready=0. Release → next instruction accepted the same cycle.
- flush with ADDI x4 held and ex_ready=1 → ex_valid=0 next cycle, busy[4]=0, input not accepted.
- Opcode 0x7F, plus ADDI x0,x0,1 → first sets ex_illegal=1, wb_en=0; second sets wb_en=0, busy untouched. LUI x5,0xABCDE → data2=0xABCDE000.
